// File: rtl/clk_div_scheduler.sv
// Programmable clock-enable divider with start/stop/drain control and optional burst length.
// The active ratio only changes at a period boundary, so no period is ever cut short.
module clk_div_scheduler #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned BURST_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic [CNT_W-1:0]   i_div,
    input  logic               i_div_load,
    input  logic [BURST_W-1:0] i_burst,
    output logic               o_busy,
    output logic               o_clk_div,
    output logic               o_tick,
    output logic [BURST_W-1:0] o_tick_cnt,
    output logic               o_done
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   ratio;
    logic [CNT_W-1:0]   ratio_pend;
    logic [BURST_W-1:0] burst;
    logic [BURST_W-1:0] tick_cnt;
    logic               done;

    logic [CNT_W-1:0]   n_eff;
    logic               last;
    logic [BURST_W-1:0] tick_inc;
    logic               burst_end;

    always_comb begin
        n_eff     = (ratio < CNT_W'(2)) ? CNT_W'(2) : ratio;
        last      = (cnt == n_eff - 1'b1);
        tick_inc  = (tick_cnt == '1) ? tick_cnt : tick_cnt + 1'b1;
        burst_end = (burst != '0) && (tick_inc == burst);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            cnt        <= '0;
            ratio      <= CNT_W'(2);
            ratio_pend <= CNT_W'(2);
            burst      <= '0;
            tick_cnt   <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (i_div_load) begin
                        ratio      <= i_div;
                        ratio_pend <= i_div;
                    end
                    // The pending ratio may be newer than the active one if it was loaded late
                    // in the previous run.
                    if (i_start) begin
                        state    <= StRun;
                        cnt      <= '0;
                        tick_cnt <= '0;
                        burst    <= i_burst;
                        ratio    <= i_div_load ? i_div : ratio_pend;
                    end
                end
                default: begin
                    if (i_div_load) begin
                        ratio_pend <= i_div;
                    end
                    if (last) begin
                        cnt      <= '0;
                        ratio    <= ratio_pend;
                        tick_cnt <= tick_inc;
                        if (burst_end || (state == StDrain) || i_stop) begin
                            state <= StIdle;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                        if ((state == StRun) && i_stop) begin
                            state <= StDrain;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        o_busy     = (state != StIdle);
        o_clk_div  = (state != StIdle) && (cnt < (n_eff >> 1));
        o_tick     = (state != StIdle) && last;
        o_tick_cnt = tick_cnt;
        o_done     = done;
    end

endmodule

// File: tb/tb_clk_div_scheduler.sv
// Scoreboard bench: each driven cycle queues the expected output vector, a monitor queues
// the observed vector after the edge, and each test task compares the two queues.
module tb_clk_div_scheduler;

    typedef logic [19:0] obs_t;  // {busy, clk_div, tick, done, tick_cnt[15:0]}

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_start = 1'b0;
    logic        i_stop = 1'b0;
    logic [7:0]  i_div = 8'd0;
    logic        i_div_load = 1'b0;
    logic [15:0] i_burst = 16'd0;
    logic        o_busy;
    logic        o_clk_div;
    logic        o_tick;
    logic [15:0] o_tick_cnt;
    logic        o_done;

    obs_t exp_q[$];
    obs_t act_q[$];
    logic rec = 1'b0;
    int   passed = 0;
    int   total = 0;

    clk_div_scheduler #(.CNT_W(8), .BURST_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_start    (i_start),
        .i_stop     (i_stop),
        .i_div      (i_div),
        .i_div_load (i_div_load),
        .i_burst    (i_burst),
        .o_busy     (o_busy),
        .o_clk_div  (o_clk_div),
        .o_tick     (o_tick),
        .o_tick_cnt (o_tick_cnt),
        .o_done     (o_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rec) begin
            #1;
            act_q.push_back({o_busy, o_clk_div, o_tick, o_done, o_tick_cnt});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
        $fatal(1, "timeout");
    end

    function automatic obs_t mk(input logic b, input logic c, input logic t, input logic d,
                                input int tc);
        return {b, c, t, d, 16'(tc)};
    endfunction

    // Applies inputs for the next edge and queues what the outputs must be after it.
    task automatic drive(input logic rst, input logic st, input logic sp, input logic [7:0] dv,
                         input logic ld, input logic [15:0] bu, input obs_t e);
        @(negedge clk);
        reset      = rst;
        i_start    = st;
        i_stop     = sp;
        i_div      = dv;
        i_div_load = ld;
        i_burst    = bu;
        exp_q.push_back(e);
        rec = 1'b1;
    endtask

    task automatic settle();
        @(negedge clk);
        rec        = 1'b0;
        reset      = 1'b0;
        i_start    = 1'b0;
        i_stop     = 1'b0;
        i_div_load = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e, a;
        int idx = 0;
        drive(1, 1, 0, 8'd8, 1, 16'd0, mk(0, 0, 0, 0, 0));
        drive(1, 1, 1, 8'd8, 1, 16'd0, mk(0, 0, 0, 0, 0));
        drive(0, 0, 0, 8'd0, 0, 16'd0, mk(0, 0, 0, 0, 0));
        settle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (act_q.size() == 0) begin
                $display("FAIL reset[%0d]: no sample, required %h", idx, e);
            end else begin
                a = act_q.pop_front();
                if (a !== e) $display("FAIL reset[%0d]: got %h required %h", idx, a, e);
                else passed++;
            end
            idx++;
        end
    endtask

    task automatic test_free_run();
        obs_t e, a;
        int idx = 0;
        drive(0, 1, 0, 8'd8, 1, 16'd0, mk(1, 1, 0, 0, 0));
        for (int k = 1; k < 24; k++) begin
            drive(0, 0, 0, 8'd8, 0, 16'd0, mk(1, (k % 8) < 4, (k % 8) == 7, 0, k / 8));
        end
        drive(0, 0, 1, 8'd8, 0, 16'd0, mk(0, 0, 0, 1, 3));
        drive(0, 0, 0, 8'd8, 0, 16'd0, mk(0, 0, 0, 0, 3));
        settle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (act_q.size() == 0) begin
                $display("FAIL free_run[%0d]: no sample, required %h", idx, e);
            end else begin
                a = act_q.pop_front();
                if (a !== e) $display("FAIL free_run[%0d]: got %h required %h", idx, a, e);
                else passed++;
            end
            idx++;
        end
    endtask

    task automatic test_burst();
        obs_t e, a;
        int idx = 0;
        drive(0, 1, 0, 8'd4, 1, 16'd3, mk(1, 1, 0, 0, 0));
        for (int k = 1; k < 12; k++) begin
            // A start pulse mid-run must be ignored.
            drive(0, k == 5, 0, 8'd4, 0, 16'd1, mk(1, (k % 4) < 2, (k % 4) == 3, 0, k / 4));
        end
        drive(0, 0, 0, 8'd4, 0, 16'd0, mk(0, 0, 0, 1, 3));
        drive(0, 0, 0, 8'd4, 0, 16'd0, mk(0, 0, 0, 0, 3));
        settle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (act_q.size() == 0) begin
                $display("FAIL burst[%0d]: no sample, required %h", idx, e);
            end else begin
                a = act_q.pop_front();
                if (a !== e) $display("FAIL burst[%0d]: got %h required %h", idx, a, e);
                else passed++;
            end
            idx++;
        end
    endtask

    task automatic test_stop();
        obs_t e, a;
        int idx = 0;
        drive(0, 1, 0, 8'd8, 1, 16'd0, mk(1, 1, 0, 0, 0));
        drive(0, 0, 0, 8'd8, 0, 16'd0, mk(1, 1, 0, 0, 0));
        drive(0, 0, 0, 8'd8, 0, 16'd0, mk(1, 1, 0, 0, 0));
        drive(0, 0, 1, 8'd8, 0, 16'd0, mk(1, 1, 0, 0, 0));
        for (int k = 4; k < 8; k++) begin
            drive(0, 0, 0, 8'd8, 0, 16'd0, mk(1, k < 4, k == 7, 0, 0));
        end
        drive(0, 0, 0, 8'd8, 0, 16'd0, mk(0, 0, 0, 1, 1));
        // Start and stop together in IDLE: the start wins.
        drive(0, 1, 1, 8'd8, 0, 16'd0, mk(1, 1, 0, 0, 0));
        for (int k = 1; k < 8; k++) begin
            drive(0, 0, 0, 8'd8, 0, 16'd0, mk(1, k < 4, k == 7, 0, 0));
        end
        drive(0, 0, 1, 8'd8, 0, 16'd0, mk(0, 0, 0, 1, 1));
        drive(0, 0, 0, 8'd8, 0, 16'd0, mk(0, 0, 0, 0, 1));
        settle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (act_q.size() == 0) begin
                $display("FAIL stop[%0d]: no sample, required %h", idx, e);
            end else begin
                a = act_q.pop_front();
                if (a !== e) $display("FAIL stop[%0d]: got %h required %h", idx, a, e);
                else passed++;
            end
            idx++;
        end
    endtask

    task automatic test_ratio_change();
        obs_t e, a;
        int idx = 0;
        drive(0, 1, 0, 8'd8, 1, 16'd0, mk(1, 1, 0, 0, 0));
        for (int k = 1; k < 8; k++) begin
            drive(0, 0, 0, 8'd4, k == 4, 16'd0, mk(1, k < 4, k == 7, 0, 0));
        end
        for (int k = 8; k < 16; k++) begin
            drive(0, 0, 0, 8'd4, 0, 16'd0,
                  mk(1, ((k - 8) % 4) < 2, ((k - 8) % 4) == 3, 0, 1 + (k - 8) / 4));
        end
        drive(0, 0, 1, 8'd4, 0, 16'd0, mk(0, 0, 0, 1, 3));
        drive(0, 0, 0, 8'd4, 0, 16'd0, mk(0, 0, 0, 0, 3));
        settle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (act_q.size() == 0) begin
                $display("FAIL ratio_change[%0d]: no sample, required %h", idx, e);
            end else begin
                a = act_q.pop_front();
                if (a !== e) $display("FAIL ratio_change[%0d]: got %h required %h", idx, a, e);
                else passed++;
            end
            idx++;
        end
    endtask

    task automatic test_small_ratios();
        obs_t e, a;
        int idx = 0;
        int divs[3] = '{0, 1, 3};
        for (int j = 0; j < 3; j++) begin
            int n = (divs[j] < 2) ? 2 : divs[j];
            drive(0, 1, 0, 8'(divs[j]), 1, 16'd0, mk(1, 1, 0, 0, 0));
            for (int k = 1; k < 2 * n; k++) begin
                drive(0, 0, 0, 8'd0, 0, 16'd0,
                      mk(1, (k % n) < (n / 2), (k % n) == n - 1, 0, k / n));
            end
            drive(0, 0, 1, 8'd0, 0, 16'd0, mk(0, 0, 0, 1, 2));
            drive(0, 0, 0, 8'd0, 0, 16'd0, mk(0, 0, 0, 0, 2));
        end
        settle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (act_q.size() == 0) begin
                $display("FAIL small_ratios[%0d]: no sample, required %h", idx, e);
            end else begin
                a = act_q.pop_front();
                if (a !== e) $display("FAIL small_ratios[%0d]: got %h required %h", idx, a, e);
                else passed++;
            end
            idx++;
        end
    endtask

    task automatic test_reset_mid();
        obs_t e, a;
        int idx = 0;
        drive(0, 1, 0, 8'd8, 1, 16'd0, mk(1, 1, 0, 0, 0));
        for (int k = 1; k < 6; k++) begin
            drive(0, 0, 0, 8'd8, 0, 16'd0, mk(1, k < 4, 0, 0, 0));
        end
        drive(1, 1, 1, 8'd8, 1, 16'd0, mk(0, 0, 0, 0, 0));
        drive(0, 0, 0, 8'd8, 0, 16'd0, mk(0, 0, 0, 0, 0));
        drive(0, 1, 0, 8'd8, 0, 16'd0, mk(1, 1, 0, 0, 0));
        for (int k = 1; k < 4; k++) begin
            drive(0, 0, 0, 8'd8, 0, 16'd0, mk(1, (k % 2) < 1, (k % 2) == 1, 0, k / 2));
        end
        drive(0, 0, 1, 8'd8, 0, 16'd0, mk(0, 0, 0, 1, 2));
        drive(0, 0, 0, 8'd8, 0, 16'd0, mk(0, 0, 0, 0, 2));
        settle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (act_q.size() == 0) begin
                $display("FAIL reset_mid[%0d]: no sample, required %h", idx, e);
            end else begin
                a = act_q.pop_front();
                if (a !== e) $display("FAIL reset_mid[%0d]: got %h required %h", idx, a, e);
                else passed++;
            end
            idx++;
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_burst();
        test_stop();
        test_ratio_change();
        test_small_ratios();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/clk_div_scheduler.md
CLK_DIV_SCHEDULER -- requirements
Module: clk_div_scheduler

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the divide-ratio field and the period counter.
REQ-002 SHALL have parameter BURST_W, default 16: width of the burst length and tick counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_start  input  1  start request, sampled each cycle.
REQ-006 SHALL have port i_stop  input  1  stop request, sampled each cycle.
REQ-007 SHALL have port i_div  input  CNT_W  requested divide ratio N.
REQ-008 SHALL have port i_div_load  input  1  load i_div as the new ratio.
REQ-009 SHALL have port i_burst  input  BURST_W  tick count per run; 0 = free-run.
REQ-010 SHALL have port o_busy  output  1  high in RUN or DRAIN.
REQ-011 SHALL have port o_clk_div  output  1  divided clock-enable waveform.
REQ-012 SHALL have port o_tick  output  1  one-cycle pulse in the last cycle of each period.
REQ-013 SHALL have port o_tick_cnt  output  BURST_W  ticks since last start.
REQ-014 SHALL have port o_done  output  1  one-cycle run-completion pulse.

Function
REQ-015 SHALL implement states IDLE, RUN and DRAIN, plus a period counter cnt, an active ratio register, a pending ratio register and a burst register.
REQ-016 SHALL compute the effective ratio as max(ratio, 2), so that i_div of 0 or 1 behaves as 2.
REQ-017 SHALL count cnt 0..N-1 while not IDLE, and wrap to 0 after N-1.
REQ-018 SHALL drive o_clk_div = (state != IDLE) and (cnt < N>>1); for odd N, the high phase is floor(N/2) cycles.
REQ-019 SHALL drive o_tick = (state != IDLE) and (cnt == N-1).
REQ-020 SHALL, in IDLE with i_start=1, enter RUN on the next edge with cnt=0, o_tick_cnt=0, burst latched from i_burst, and active ratio latched from i_div if i_div_load=1, else from the pending ratio.
REQ-021 SHALL, in IDLE, make i_div_load update both the active and pending ratio registers.
REQ-022 SHALL, in RUN/DRAIN, make i_div_load update only the pending ratio; the active ratio SHALL take the pending value on the edge where cnt wraps, never mid-period.
REQ-023 SHALL ignore i_start while o_busy=1, and SHALL ignore i_stop in IDLE, so that simultaneous start+stop in IDLE starts the run.
REQ-024 SHALL, on i_stop in RUN when cnt != N-1, enter DRAIN and complete the current period.
REQ-025 SHALL, on i_stop in RUN when cnt == N-1, go directly to IDLE on the next edge.
REQ-026 SHALL, in DRAIN at cnt == N-1, go to IDLE on the next edge.
REQ-027 SHALL increment o_tick_cnt on every o_tick, saturating at all-ones.
REQ-028 SHALL, with a nonzero burst register, go to IDLE on the edge after the tick that brings o_tick_cnt equal to the burst value.
REQ-029 SHALL assert o_done (registered) for exactly one cycle, coincident with the first IDLE cycle after any run ends (burst end, stop, or drain).
REQ-030 SHALL keep o_tick_cnt holding its final value in IDLE until the next start.

Reset
REQ-031 SHALL, when reset=1 at an edge, force on the next cycle: state=IDLE, cnt=0, o_busy=0, o_clk_div=0, o_tick=0, o_done=0, o_tick_cnt=0, active/pending ratio=2 and burst=0, regardless of current state.
REQ-032 SHALL give reset priority over i_start, i_stop and i_div_load, and SHALL produce no o_done pulse from a reset-aborted run.

Verification
REQ-033 SHALL be verified by: reset; i_div=8 with load, start, burst=0 -> o_clk_div 4 high/4 low; o_tick every 8th cycle, first 8 cycles after start.
REQ-034 SHALL be verified by: i_div=4, burst=3, start -> exactly 3 ticks; the cycle after the 3rd tick has o_busy=0, o_done=1 and o_tick_cnt=3.
REQ-035 SHALL be verified by: N=8, i_stop at cnt=2 -> DRAIN; tick at cnt=7; then IDLE with o_done=1; then i_stop at cnt=7 -> same-cycle tick, then IDLE.
REQ-036 SHALL be verified by: running at N=8, load i_div=4 at cnt=3 -> current period 8 cycles, following periods 4 cycles, and no shortened period.
REQ-037 SHALL be verified by: i_div=0, then 1, then 3 -> periods of 2, 2 and 3 cycles; for N=3, o_clk_div is high 1 cycle and low 2.
REQ-038 SHALL be verified by: reset mid-RUN at cnt=5 -> next cycle all outputs 0, no o_done; then start with no load -> ratio 2.
